laser_lane_receiver: RTL

//  Receive side of the 4-lane LaserDrop optical link; the transmit side drives GPIO_1_D14..D17 and this block samples GPIO_0_D14..D17.

---
 rtl/laser_lane_receiver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/laser_lane_receiver.sv
// laser_lane_receiver: LaserDrop 4-lane optical receiver (START hunt, nibble-pair deserialiser, byte handshake).
// Define LASER_RX_CHECKSUM_EN to expect a trailing XOR checksum byte before STOP.
module laser_lane_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PACKET_BYTES = 2
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [3:0] lanes,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  input  logic       rx_byte_ready,
  output logic       data_valid,
  output logic       frame_error,
  output logic [7:0] byte_count
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    LAST_BYTE = 8'(PACKET_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START_CHK, DATA, CSUM, STOP} state_t;

  state_t        state;
  logic [3:0]    sync1;
  logic [3:0]    sym;
  logic          armed;
  logic [CW-1:0] bit_cnt;
  logic          nib_hi;
  logic [3:0]    low_nib;
  logic [7:0]    byte_idx;
  logic          bad;
`ifdef LASER_RX_CHECKSUM_EN
  logic [7:0]    csum_xor;
`endif

  logic       full_tick;
  logic [7:0] assembled;
  assign full_tick = (bit_cnt == FULL_LAST);
  assign assembled = {sym, low_nib};

  // Sample points sit mid-symbol: half a symbol after START is seen, then every full symbol.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      sync1         <= 4'h0;
      sym           <= 4'h0;
      armed         <= 1'b0;
      bit_cnt       <= '0;
      nib_hi        <= 1'b0;
      low_nib       <= 4'h0;
      byte_idx      <= 8'h00;
      bad           <= 1'b0;
`ifdef LASER_RX_CHECKSUM_EN
      csum_xor      <= 8'h00;
`endif
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      data_valid    <= 1'b0;
      frame_error   <= 1'b0;
      byte_count    <= 8'h00;
    end else begin
      sync1       <= lanes;
      sym         <= sync1;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      bit_cnt     <= bit_cnt + CW'(1);
      if (rx_byte_valid && rx_byte_ready) rx_byte_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (sym == 4'h0) armed <= 1'b1;
          if (armed && sym == 4'hF) begin
            state   <= START_CHK;
            bit_cnt <= '0;
          end
        end
        START_CHK: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (sym == 4'hF) begin
              state      <= DATA;
              nib_hi     <= 1'b0;
              byte_idx   <= 8'h00;
              byte_count <= 8'h00;
              bad        <= 1'b0;
`ifdef LASER_RX_CHECKSUM_EN
              csum_xor   <= 8'h00;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (full_tick) begin
            bit_cnt <= '0;
            nib_hi  <= !nib_hi;
            if (!nib_hi) begin
              low_nib <= sym;
            end else begin
`ifdef LASER_RX_CHECKSUM_EN
              csum_xor <= csum_xor ^ assembled;
`endif
              // A byte still waiting for the consumer is never overwritten.
              if (!rx_byte_valid || rx_byte_ready) begin
                rx_byte       <= assembled;
                rx_byte_valid <= 1'b1;
                byte_count    <= byte_count + 8'd1;
              end else begin
                bad <= 1'b1;
              end
              byte_idx <= byte_idx + 8'd1;
`ifdef LASER_RX_CHECKSUM_EN
              if (byte_idx == LAST_BYTE) state <= CSUM;
`else
              if (byte_idx == LAST_BYTE) state <= STOP;
`endif
            end
          end
        end
`ifdef LASER_RX_CHECKSUM_EN
        CSUM: begin
          if (full_tick) begin
            bit_cnt <= '0;
            nib_hi  <= !nib_hi;
            if (!nib_hi) begin
              low_nib <= sym;
            end else begin
              if (assembled != csum_xor) bad <= 1'b1;
              state <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (full_tick) begin
            bit_cnt <= '0;
            if (sym == 4'h0 && !bad) data_valid <= 1'b1;
            else frame_error <= 1'b1;
            state <= IDLE;
            armed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
